// File: rtl/cdr_loop_ctrl.sv
// rtl/cdr_loop_ctrl.sv - CDR loop sequencer: pulse gating, gain schedule and lock detection
module cdr_loop_ctrl #(
    parameter int WIN_LOG2    = 6,
    parameter int ACQ_CYCLES  = 1024,
    parameter int LOCK_TOL    = 4,
    parameter int LOCK_WINS   = 4,
    parameter int UNLOCK_TOL  = 16,
    parameter int UNLOCK_WINS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       hold,
    input  logic       up_in,
    input  logic       dn_in,
    output logic       up_out,
    output logic       dn_out,
    output logic       filt_rst_n,
    output logic [1:0] gain_sel,
    output logic [1:0] state,
    output logic       locked
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACQ   = 2'd1,
        S_TRACK = 2'd2,
        S_LOCK  = 2'd3
    } state_t;

    localparam int ACQ_W  = $clog2(ACQ_CYCLES + 1);
    localparam int NET_W  = WIN_LOG2 + 2;
    localparam int GOOD_W = $clog2(LOCK_WINS + 1);
    localparam int BAD_W  = $clog2(UNLOCK_WINS + 1);

    localparam logic [ACQ_W-1:0]        ACQ_LAST     = ACQ_W'(ACQ_CYCLES - 1);
    localparam logic [WIN_LOG2-1:0]     WIN_LAST     = '1;
    localparam logic signed [NET_W-1:0] NET_MAX      = NET_W'(2 ** WIN_LOG2);
    localparam logic signed [NET_W-1:0] NET_MIN      = NET_W'(-(2 ** WIN_LOG2));
    localparam logic signed [NET_W:0]   NET_ONE      = 1;
    localparam logic [NET_W-1:0]        LOCK_TOL_W   = NET_W'(LOCK_TOL);
    localparam logic [NET_W-1:0]        UNLOCK_TOL_W = NET_W'(UNLOCK_TOL);
    localparam logic [GOOD_W-1:0]       GOOD_LAST    = GOOD_W'(LOCK_WINS - 1);
    localparam logic [BAD_W-1:0]        BAD_LAST     = BAD_W'(UNLOCK_WINS - 1);

    state_t                  state_q, state_d;
    logic [ACQ_W-1:0]        acq_cnt_q, acq_cnt_d;
    logic [WIN_LOG2-1:0]     win_cnt_q, win_cnt_d;
    logic signed [NET_W-1:0] net_q, net_d;
    logic [GOOD_W-1:0]       good_cnt_q, good_cnt_d;
    logic [BAD_W-1:0]        bad_cnt_q, bad_cnt_d;

    logic       up_out_q, up_out_d;
    logic       dn_out_q, dn_out_d;
    logic       filt_rst_n_q, filt_rst_n_d;
    logic [1:0] gain_sel_q, gain_sel_d;
    logic       locked_q, locked_d;

    logic                    up_valid, dn_valid, active;
    logic signed [NET_W:0]   net_ext, net_sum;
    logic signed [NET_W-1:0] net_nxt;
    logic [NET_W-1:0]        net_abs;
    logic                    win_end, win_balanced, win_bad;

    // Conflicting up/dn samples are neither forwarded nor counted.
    always_comb begin
        up_valid = up_in & ~dn_in;
        dn_valid = dn_in & ~up_in;
        active   = (state_q != S_IDLE) & en;

        net_ext = {net_q[NET_W-1], net_q};
        if (up_valid) begin
            net_sum = net_ext + NET_ONE;
        end else if (dn_valid) begin
            net_sum = net_ext - NET_ONE;
        end else begin
            net_sum = net_ext;
        end

        if (net_sum > NET_MAX) begin
            net_nxt = NET_MAX;
        end else if (net_sum < NET_MIN) begin
            net_nxt = NET_MIN;
        end else begin
            net_nxt = net_sum[NET_W-1:0];
        end

        net_abs      = net_nxt[NET_W-1] ? -net_nxt : net_nxt;
        win_end      = (win_cnt_q == WIN_LAST);
        win_balanced = (net_abs <= LOCK_TOL_W);
        win_bad      = (net_abs > UNLOCK_TOL_W);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            acq_cnt_q    <= '0;
            win_cnt_q    <= '0;
            net_q        <= '0;
            good_cnt_q   <= '0;
            bad_cnt_q    <= '0;
            up_out_q     <= 1'b0;
            dn_out_q     <= 1'b0;
            filt_rst_n_q <= 1'b0;
            gain_sel_q   <= 2'b00;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            acq_cnt_q    <= acq_cnt_d;
            win_cnt_q    <= win_cnt_d;
            net_q        <= net_d;
            good_cnt_q   <= good_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            up_out_q     <= up_out_d;
            dn_out_q     <= dn_out_d;
            filt_rst_n_q <= filt_rst_n_d;
            gain_sel_q   <= gain_sel_d;
            locked_q     <= locked_d;
        end
    end

    // Dropping en wins over everything; hold freezes every transition and counter.
    always_comb begin
        state_d    = state_q;
        acq_cnt_d  = acq_cnt_q;
        win_cnt_d  = win_cnt_q;
        net_d      = net_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;

        if (!en) begin
            state_d    = S_IDLE;
            acq_cnt_d  = '0;
            win_cnt_d  = '0;
            net_d      = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else if (!hold) begin
            unique case (state_q)
                S_IDLE: begin
                    state_d   = S_ACQ;
                    acq_cnt_d = '0;
                end
                S_ACQ: begin
                    if (acq_cnt_q == ACQ_LAST) begin
                        state_d    = S_TRACK;
                        acq_cnt_d  = '0;
                        win_cnt_d  = '0;
                        net_d      = '0;
                        good_cnt_d = '0;
                        bad_cnt_d  = '0;
                    end else begin
                        acq_cnt_d = acq_cnt_q + 1'b1;
                    end
                end
                S_TRACK, S_LOCK: begin
                    if (!win_end) begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        net_d     = net_nxt;
                    end else begin
                        win_cnt_d = '0;
                        net_d     = '0;
                        if (state_q == S_TRACK) begin
                            if (!win_balanced) begin
                                good_cnt_d = '0;
                            end else if (good_cnt_q == GOOD_LAST) begin
                                state_d    = S_LOCK;
                                good_cnt_d = '0;
                                bad_cnt_d  = '0;
                            end else begin
                                good_cnt_d = good_cnt_q + 1'b1;
                            end
                        end else begin
                            if (!win_bad) begin
                                bad_cnt_d = '0;
                            end else if (bad_cnt_q == BAD_LAST) begin
                                state_d    = S_TRACK;
                                good_cnt_d = '0;
                                bad_cnt_d  = '0;
                            end else begin
                                bad_cnt_d = bad_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Status outputs follow the next state so they move together with the state register.
    always_comb begin
        up_out_d     = up_valid & active & ~hold;
        dn_out_d     = dn_valid & active & ~hold;
        filt_rst_n_d = (state_d != S_IDLE);
        locked_d     = (state_d == S_LOCK);
        unique case (state_d)
            S_ACQ:   gain_sel_d = 2'b10;
            S_TRACK: gain_sel_d = 2'b01;
            default: gain_sel_d = 2'b00;
        endcase
    end

    assign up_out     = up_out_q;
    assign dn_out     = dn_out_q;
    assign filt_rst_n = filt_rst_n_q;
    assign gain_sel   = gain_sel_q;
    assign state      = state_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_cdr_loop_ctrl.sv
// tb/tb_cdr_loop_ctrl.sv - self-checking bench for cdr_loop_ctrl
module tb_cdr_loop_ctrl;

    localparam int WIN         = 64;
    localparam int ACQ         = 1024;
    localparam int LOCK_TOL    = 4;
    localparam int LOCK_WINS   = 4;
    localparam int UNLOCK_TOL  = 16;
    localparam int UNLOCK_WINS = 2;

    logic       clk;
    logic       rst_n, en, hold, up_in, dn_in;
    logic       up_out, dn_out, filt_rst_n, locked;
    logic [1:0] gain_sel, state;

    int n_assert;
    int n_fail;

    int m_phase, m_acq_done, m_win_pos, m_net, m_good, m_bad;
    bit m_up, m_dn;

    cdr_loop_ctrl #(
        .WIN_LOG2   (6),
        .ACQ_CYCLES (ACQ),
        .LOCK_TOL   (LOCK_TOL),
        .LOCK_WINS  (LOCK_WINS),
        .UNLOCK_TOL (UNLOCK_TOL),
        .UNLOCK_WINS(UNLOCK_WINS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .hold      (hold),
        .up_in     (up_in),
        .dn_in     (dn_in),
        .up_out    (up_out),
        .dn_out    (dn_out),
        .filt_rst_n(filt_rst_n),
        .gain_sel  (gain_sel),
        .state     (state),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Phases: 0 idle, 1 acquisition, 2 tracking, 3 locked.
    task automatic model_clear();
        m_acq_done = 0;
        m_win_pos  = 0;
        m_net      = 0;
        m_good     = 0;
        m_bad      = 0;
    endtask

    task automatic model(input bit r, input bit e, input bit h, input bit u, input bit d);
        int step_v, mag;
        if (!r) begin
            m_phase = 0;
            model_clear();
            m_up = 0;
            m_dn = 0;
            return;
        end
        m_up = u && !d && e && (m_phase != 0) && !h;
        m_dn = d && !u && e && (m_phase != 0) && !h;
        if (!e) begin
            m_phase = 0;
            model_clear();
        end else if (!h) begin
            if (m_phase == 0) begin
                m_phase = 1;
                model_clear();
            end else if (m_phase == 1) begin
                m_acq_done++;
                if (m_acq_done == ACQ) begin
                    m_phase = 2;
                    model_clear();
                end
            end else begin
                step_v = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
                m_net  = m_net + step_v;
                if (m_net > WIN)  m_net = WIN;
                if (m_net < -WIN) m_net = -WIN;
                m_win_pos++;
                if (m_win_pos == WIN) begin
                    mag = (m_net < 0) ? -m_net : m_net;
                    m_win_pos = 0;
                    m_net = 0;
                    if (m_phase == 2) begin
                        m_good = (mag <= LOCK_TOL) ? m_good + 1 : 0;
                        if (m_good == LOCK_WINS) begin
                            m_phase = 3;
                            model_clear();
                        end
                    end else begin
                        m_bad = (mag > UNLOCK_TOL) ? m_bad + 1 : 0;
                        if (m_bad == UNLOCK_WINS) begin
                            m_phase = 2;
                            model_clear();
                        end
                    end
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input bit h, input bit u, input bit d);
        int exp_gain;
        rst_n = r;
        en    = e;
        hold  = h;
        up_in = u;
        dn_in = d;
        @(posedge clk);
        #1;
        model(r, e, h, u, d);
        exp_gain = (m_phase == 1) ? 2 : ((m_phase == 2) ? 1 : 0);
        chk("state", state, m_phase);
        chk("up_out", up_out, m_up);
        chk("dn_out", dn_out, m_dn);
        chk("filt_rst_n", filt_rst_n, m_phase != 0);
        chk("gain_sel", gain_sel, exp_gain);
        chk("locked", locked, m_phase == 3);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_filt"}, filt_rst_n, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_gain"}, gain_sel, 0);
        chk({tag, "_pulses"}, {up_out, dn_out}, 0);
    endtask

    initial begin
        int first;
        bit ru, rd, rr, re, rh;
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0; en = 1'b0; hold = 1'b0; up_in = 1'b0; dn_in = 1'b0;
        m_phase = 0;
        model_clear();

        for (int i = 0; i < 3; i++) step(0, 1, 0, 1'($urandom), 1'($urandom));
        chk_idle("reset");

        first = -1;
        for (int i = 1; i <= 1400; i++) begin
            step(1, 1, 0, 1'(i % 2), 1'((i + 1) % 2));
            if (i == 1) begin
                chk("acq_entry_state", state, 1);
                chk("acq_entry_gain", gain_sel, 2);
                chk("acq_entry_pulse_blocked", {up_out, dn_out}, 0);
            end
            if (i == 2)    chk("first_forwarded_dn", dn_out, 1);
            if (i == 1024) chk("acq_last_state", state, 1);
            if (i == 1025) chk("track_entry_gain", gain_sel, 1);
            if (locked) begin
                first = i;
                break;
            end
        end
        chk("lock_time", first, 1 + ACQ + LOCK_WINS * WIN);
        chk("lock_gain", gain_sel, 0);

        first = -1;
        for (int i = 1; i <= 256; i++) begin
            if ((i - 1) / WIN == 1) step(1, 1, 0, 1'(i % 2), 1'((i + 1) % 2));
            else                    step(1, 1, 0, 1, 0);
            if (i == 192) chk("balanced_keeps_lock", locked, 1);
            if (state == 2 && first < 0) first = i;
        end
        chk("unlock_time", first, 256);
        chk("unlock_locked", locked, 0);

        first = -1;
        for (int i = 1; i <= 300; i++) begin
            step(1, 1, 0, 1, 1);
            chk("conflict_pulses", {up_out, dn_out}, 0);
            if (locked) begin
                first = i;
                break;
            end
        end
        chk("conflict_lock_time", first, LOCK_WINS * WIN);

        step(1, 0, 0, 1'($urandom), 1'($urandom));
        chk_idle("en_abort");
        first = -1;
        for (int i = 1; i <= 1100; i++) begin
            step(1, 1, 0, 1'($urandom), 1'($urandom));
            if (state == 2) begin
                first = i;
                break;
            end
        end
        chk("en_reacq_time", first, 1 + ACQ);
        for (int i = 1; i <= 300 && !locked; i++) step(1, 1, 0, 1'(i % 2), 1'((i + 1) % 2));
        chk("relock", locked, 1);

        step(0, 1, 0, 1'($urandom), 1'($urandom));
        chk_idle("rst_abort");
        first = -1;
        for (int i = 1; i <= 1300; i++) begin
            rh = (i > 300 && i <= 400);
            step(1, 1, rh, 1'($urandom), 1'($urandom));
            if (rh) chk("hold_pulses", {up_out, dn_out}, 0);
            if (state == 2) begin
                first = i;
                break;
            end
        end
        chk("hold_acq_exit", first, 1 + ACQ + 100);

        for (int i = 0; i < 4000; i++) begin
            int mode;
            mode = (i / 300) % 3;
            rr = ($urandom_range(4999) != 0);
            re = ($urandom_range(2499) != 0);
            rh = ($urandom_range(39) == 0);
            ru = 1'($urandom);
            rd = 1'($urandom);
            if (mode == 1 && $urandom_range(9) != 0) begin
                ru = 1'(i % 2);
                rd = 1'((i + 1) % 2);
            end else if (mode == 2 && $urandom_range(9) != 0) begin
                ru = 1;
                rd = 0;
            end
            step(rr, re, rh, ru, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
